// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor, including the fetch stage.
package simple_processor_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;
    localparam int INSTR_STEP = 2;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; flush has priority over push and pop in the same cycle.
module fetch_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [31:0]
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  entry_t                   data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output entry_t                   head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_do_pop  = pop_i && (r_count != '0);
    assign w_do_push = push_i && ((r_count != FULL_CNT) || w_do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= data_i;
    end

    assign full_o  = (r_count == FULL_CNT);
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, runs the single-outstanding IMEM handshake
// and feeds PC-tagged instructions to the decoder through a prefetch FIFO.
module instr_fetch
    import simple_processor_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = DATA_WIDTH,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [MEM_ADDR_WIDTH-1:0] boot_addr_i,
    output logic                      imem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [MEM_DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                      imem_ack_i,
    input  logic                      redirect_i,
    input  logic [MEM_ADDR_WIDTH-1:0] redirect_addr_i,
    output logic                      if_valid_o,
    output logic [MEM_DATA_WIDTH-1:0] if_instr_o,
    output logic [MEM_ADDR_WIDTH-1:0] if_pc_o,
    input  logic                      if_ready_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    fetch_state_t              r_state;
    fetch_state_t              w_next_state;
    logic [MEM_ADDR_WIDTH-1:0] r_fetch_pc;
    logic [MEM_ADDR_WIDTH-1:0] r_tgt_pc;
    logic                      r_pending;
    logic [MEM_ADDR_WIDTH-1:0] w_fetch_pc_nxt;
    logic [MEM_ADDR_WIDTH-1:0] w_tgt_pc_nxt;
    logic                      w_req;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_flush;
    logic                      w_unused_full;
    logic                      w_empty;
    logic [CNT_W-1:0]          w_count;
    fetch_entry_t              w_push_entry;
    fetch_entry_t              w_head;

    always_comb begin
        w_next_state   = r_state;
        w_req          = 1'b0;
        w_push         = 1'b0;
        w_flush        = 1'b0;
        w_fetch_pc_nxt = r_fetch_pc;
        w_tgt_pc_nxt   = r_tgt_pc;
        case (r_state)
            BOOT: w_next_state = FETCH;
            FETCH: begin
                w_req = (w_count < DEPTH_CNT) || r_pending;
                if (redirect_i) begin
                    w_flush = 1'b1;
                    // A request raised this cycle without an ack must still be completed.
                    if (w_req && !imem_ack_i) begin
                        w_tgt_pc_nxt = redirect_addr_i;
                        w_next_state = DISCARD;
                    end else begin
                        w_fetch_pc_nxt = redirect_addr_i;
                    end
                end else if (w_req && imem_ack_i) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + MEM_ADDR_WIDTH'(INSTR_STEP);
                end
            end
            DISCARD: begin
                w_req = 1'b1;
                if (redirect_i) begin
                    w_flush      = 1'b1;
                    w_tgt_pc_nxt = redirect_addr_i;
                end
                if (imem_ack_i) begin
                    w_next_state   = FETCH;
                    w_fetch_pc_nxt = redirect_i ? redirect_addr_i : r_tgt_pc;
                end
            end
            default: w_next_state = BOOT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= BOOT;
            r_fetch_pc <= boot_addr_i;
            r_tgt_pc   <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_tgt_pc   <= w_tgt_pc_nxt;
            r_pending  <= w_req && !imem_ack_i;
        end
    end

    assign w_pop              = if_valid_o && if_ready_i;
    assign w_push_entry.pc    = r_fetch_pc;
    assign w_push_entry.instr = imem_rdata_i;

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (w_flush),
        .data_i  (w_push_entry),
        .full_o  (w_unused_full),
        .empty_o (w_empty),
        .count_o (w_count),
        .head_o  (w_head)
    );

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fetch_pc;
    assign if_valid_o  = !w_empty;
    assign if_instr_o  = w_head.instr;
    assign if_pc_o     = w_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: IMEM responder with programmable wait states, a program-order
// reference model feeding an expected queue, and a monitor on the decoder interface.
module tb_instr_fetch;
    import simple_processor_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] boot_addr_i = 16'h0100;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic [DW-1:0] imem_rdata_i = '0;
    logic          imem_ack_i = 1'b0;
    logic          redirect_i = 1'b0;
    logic [AW-1:0] redirect_addr_i = '0;
    logic          if_valid_o;
    logic [DW-1:0] if_instr_o;
    logic [AW-1:0] if_pc_o;
    logic          if_ready_i = 1'b1;

    always #5 clk = ~clk;

    instr_fetch #(
        .MEM_ADDR_WIDTH (AW),
        .MEM_DATA_WIDTH (DW),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .boot_addr_i     (boot_addr_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_rdata_i    (imem_rdata_i),
        .imem_ack_i      (imem_ack_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .if_valid_o      (if_valid_o),
        .if_instr_o      (if_instr_o),
        .if_pc_o         (if_pc_o),
        .if_ready_i      (if_ready_i)
    );

    int tests      = 0;
    int fails      = 0;
    int pops_total = 0;

    logic [AW+DW-1:0] exp_q[$];
    int               wait_cfg     = 0;
    int               mem_wait_cnt = 0;
    logic             held_valid   = 1'b0;
    logic [AW-1:0]    held_addr    = '0;
    logic [AW-1:0]    model_pc     = '0;
    logic             drop_next    = 1'b0;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        logic [DW-1:0] t;
        t = a * 16'd3;
        return t ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // IMEM responder, handshake checker, output monitor and reference model in one
    // process so that every decision in a cycle sees the same settled signals.
    always @(negedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            model_pc     = boot_addr_i;
            drop_next    = 1'b0;
            mem_wait_cnt = 0;
            imem_ack_i   = 1'b0;
            held_valid   = 1'b0;
        end else begin
            imem_rdata_i = mem_f(imem_addr_o);
            if (imem_req_o && mem_wait_cnt >= wait_cfg) begin
                imem_ack_i   = 1'b1;
                mem_wait_cnt = 0;
            end else begin
                imem_ack_i = 1'b0;
                if (imem_req_o) mem_wait_cnt++;
            end

            if (held_valid) begin
                check("req_held", 32'(imem_req_o), 32'd1);
                check("addr_held", 32'(imem_addr_o), 32'(held_addr));
            end
            held_valid = imem_req_o && !imem_ack_i;
            held_addr  = imem_addr_o;

            if (if_valid_o && if_ready_i) begin
                pops_total++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got pc %h instr %h expected nothing", if_pc_o, if_instr_o);
                end else begin
                    check("output_entry", {if_pc_o, if_instr_o}, exp_q.pop_front());
                end
            end

            // Program order: after a redirect the stream restarts at the target; the one
            // request in flight at that moment never reaches the decoder.
            if (redirect_i) begin
                exp_q.delete();
                model_pc  = redirect_addr_i;
                drop_next = imem_req_o && !imem_ack_i;
            end else if (imem_ack_i) begin
                if (drop_next) begin
                    drop_next = 1'b0;
                end else begin
                    exp_q.push_back({model_pc, mem_f(model_pc)});
                    model_pc = model_pc + 16'd2;
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut(input logic [AW-1:0] b);
        boot_addr_i = b;
        rst_i       = 1'b1;
        run(1);
        check("reset_req", 32'(imem_req_o), 32'd0);
        check("reset_valid", 32'(if_valid_o), 32'd0);
        check("reset_addr", 32'(imem_addr_o), 32'(b));
        rst_i = 1'b0;
        run(1);
        check("first_req", 32'(imem_req_o), 32'd1);
        check("first_addr", 32'(imem_addr_o), 32'(b));
    endtask

    task automatic wait_pending(input string name);
        int n;
        n = 0;
        while (!(imem_req_o && mem_wait_cnt < wait_cfg) && n < 50) begin
            run(1);
            n++;
        end
        check(name, 32'(n < 50), 32'd1);
    endtask

    initial begin
        int pops_before;
        @(posedge clk);
        #1;

        // Zero-wait streaming from boot address.
        wait_cfg   = 0;
        if_ready_i = 1'b1;
        reset_dut(16'h0100);
        run(12);

        // Decoder stalls: FIFO fills, request drops, and resumes right after a pop.
        if_ready_i = 1'b0;
        run(8);
        check("buffered_count", 32'(exp_q.size()), 32'(DEPTH));
        check("full_req_low", 32'(imem_req_o), 32'd0);
        check("full_valid", 32'(if_valid_o), 32'd1);
        if_ready_i = 1'b1;
        run(1);
        check("req_after_pop", 32'(imem_req_o), 32'd1);
        run(10);

        // Wait-state memory.
        wait_cfg    = 3;
        pops_before = pops_total;
        run(30);
        check("wait_progress", 32'(pops_total - pops_before >= 5), 32'd1);

        // Redirect while a request is outstanding.
        wait_cfg = 2;
        wait_pending("pending_before_redirect");
        redirect_i      = 1'b1;
        redirect_addr_i = 16'h0200;
        run(1);
        redirect_i = 1'b0;
        run(15);

        // Redirect in the ack cycle of a zero-wait fetch.
        wait_cfg = 0;
        run(3);
        check("req_before_ack_redirect", 32'(imem_req_o), 32'd1);
        redirect_i      = 1'b1;
        redirect_addr_i = 16'h0300;
        run(1);
        redirect_i = 1'b0;
        check("redirect_ack_req", 32'(imem_req_o), 32'd1);
        check("redirect_ack_addr", 32'(imem_addr_o), 32'h0300);
        run(10);

        // Random traffic: decoder stalls, memory latency and redirects.
        for (int i = 0; i < 400; i++) begin
            if_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) wait_cfg = $urandom_range(0, 3);
            redirect_i      = ($urandom_range(0, 24) == 0);
            redirect_addr_i = 16'($urandom_range(0, 32767)) << 1;
            run(1);
        end
        redirect_i = 1'b0;
        if_ready_i = 1'b1;
        wait_cfg   = 0;
        run(20);

        // Address wrap at the top of memory.
        reset_dut(16'hFFFE);
        run(10);

        // Reset in the middle of a wait-state request.
        wait_cfg = 3;
        run(2);
        wait_pending("pending_before_reset");
        wait_cfg = 0;
        reset_dut(16'h0400);
        run(15);

        check("total_progress", 32'(pops_total >= 100), 32'd1);
        run(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
